// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: per-stage control widths, field offsets,
// the bubble control constant and the stage-register occupancy encoding.
package cpu_pipe_pkg;

  localparam int IF_ID_CTRL_W  = 4;
  localparam int ID_EX_CTRL_W  = 16;
  localparam int EX_MEM_CTRL_W = 8;
  localparam int MEM_WB_CTRL_W = 4;

  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_BRANCH    = 3;
  localparam int CTRL_ALUOP_LSB = 4;
  localparam int CTRL_ALUOP_W   = 4;

  localparam logic [ID_EX_CTRL_W-1:0] CTRL_NOP = '0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat carrying one data bundle and one control bundle.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid,
    output data,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    output ready
  );

endinterface

// File: rtl/pipe_skid_entry.sv
// One data+ctrl holding register with load and clear; clear wins.
module pipe_skid_entry #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [CTRL_W-1:0] ld_ctrl,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (clear) begin
      data_d = '0;
      ctrl_d = '0;
    end else if (load) begin
      data_d = ld_data;
      ctrl_d = ld_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign data = data_q;
  assign ctrl = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: main entry plus optional skid entry,
// synchronous flush, control bundle zeroed whenever no beat is held.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W  = 96,
  parameter int CTRL_W  = 16,
  parameter bit SKID_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  pipe_stage_reg_if.slave         in_if,
  pipe_stage_reg_if.master        out_if,
  output logic [1:0]              occupancy
);

  occ_e occ_q, occ_d;
  logic in_ready_q, in_ready_d;

  logic in_ready, out_valid;
  logic accept, emit;
  logic main_ld, main_clr, main_from_skid;
  logic skid_ld, skid_clr;

  logic [DATA_W-1:0] main_data, skid_data, main_ld_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ld_ctrl;

  assign out_valid = (occ_q != OCC_EMPTY);
  assign in_ready  = SKID_EN ? in_ready_q
                             : (!out_valid || out_if.ready);
  assign accept    = in_if.valid && in_ready;
  assign emit      = out_valid && out_if.ready;

  // Flush drops the offered beat; an emit this cycle has already left.
  always_comb begin
    occ_d          = occ_q;
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      occ_d    = OCC_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_ld = 1'b1;
            occ_d   = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && emit) begin
            main_ld = 1'b1;
          end else if (accept) begin
            skid_ld = 1'b1;
            occ_d   = OCC_FULL;
          end else if (emit) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (emit) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            occ_d          = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
    in_ready_d = (occ_d != OCC_FULL);
  end

  assign main_ld_data = main_from_skid ? skid_data : in_if.data;
  assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_if.ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q      <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_skid_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (main_ld),
    .clear   (main_clr),
    .ld_data (main_ld_data),
    .ld_ctrl (main_ld_ctrl),
    .data    (main_data),
    .ctrl    (main_ctrl)
  );

  pipe_skid_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_ld),
    .clear   (skid_clr),
    .ld_data (in_if.data),
    .ld_ctrl (in_if.ctrl),
    .data    (skid_data),
    .ctrl    (skid_ctrl)
  );

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = main_data;
  assign out_if.ctrl  = out_valid ? main_ctrl : '0;
  assign occupancy    = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid and non-skid instances driven in parallel
// against a FIFO-queue reference model.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [95:0] d;
    logic [15:0] c;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [95:0] in_data = '0;
  logic [15:0] in_ctrl = '0;
  logic        out_ready = 1'b0;
  logic [1:0]  occ_a, occ_b;

  int vectors = 0;
  int miscompares = 0;

  beat_t qa[$];
  beat_t qb[$];
  beat_t emitted_a[$];
  beat_t emitted_b[$];

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(96), .CTRL_W(16)) in_a ();
  pipe_stage_reg_if #(.DATA_W(96), .CTRL_W(16)) out_a ();
  pipe_stage_reg_if #(.DATA_W(96), .CTRL_W(16)) in_b ();
  pipe_stage_reg_if #(.DATA_W(96), .CTRL_W(16)) out_b ();

  assign in_a.valid  = in_valid;
  assign in_a.data   = in_data;
  assign in_a.ctrl   = in_ctrl;
  assign out_a.ready = out_ready;
  assign in_b.valid  = in_valid;
  assign in_b.data   = in_data;
  assign in_b.ctrl   = in_ctrl;
  assign out_b.ready = out_ready;

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .SKID_EN(1'b1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_if     (in_a),
    .out_if    (out_a),
    .occupancy (occ_a)
  );

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .SKID_EN(1'b0)) u_noskid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_if     (in_b),
    .out_if    (out_b),
    .occupancy (occ_b)
  );

  // Model: a bounded FIFO per instance, updated at each rising edge.
  task automatic tick();
    beat_t nb;
    bit acc_a, acc_b, em_a, em_b;
    nb    = '{d: in_data, c: in_ctrl};
    acc_a = in_valid && (qa.size() < 2);
    acc_b = in_valid && (qb.size() == 0 || out_ready);
    em_a  = (qa.size() > 0) && out_ready;
    em_b  = (qb.size() > 0) && out_ready;
    @(posedge clk);
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      if (em_a) emitted_a.push_back(qa.pop_front());
      if (em_b) emitted_b.push_back(qb.pop_front());
      if (flush) begin
        qa.delete();
        qb.delete();
      end else begin
        if (acc_a) qa.push_back(nb);
        if (acc_b) qb.push_back(nb);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 96'h55;
    in_ctrl = 16'h3;
    tick();
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_a.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", out_a.valid); end
    vectors++;
    if (out_a.data !== 96'h0) begin miscompares++; $display("FAIL reset_data got %0h want 0", out_a.data); end
    vectors++;
    if (out_a.ctrl !== 16'h0) begin miscompares++; $display("FAIL reset_ctrl got %0h want 0", out_a.ctrl); end
    vectors++;
    if (occ_a !== 2'd0) begin miscompares++; $display("FAIL reset_occ got %0d want 0", occ_a); end
    vectors++;
    if (in_a.ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_a.ready); end
    vectors++;
    if (occ_b !== 2'd0) begin miscompares++; $display("FAIL reset_occ_b got %0d want 0", occ_b); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data = 96'(i);
      in_ctrl = 16'($urandom);
      tick();
      vectors++;
      if (out_a.valid !== 1'b1 || out_a.data !== 96'(i)) begin
        miscompares++;
        $display("FAIL stream_%0d got v=%0b d=%0h want v=1 d=%0h", i, out_a.valid, out_a.data, i);
      end
      vectors++;
      if (occ_a !== 2'd1) begin miscompares++; $display("FAIL stream_occ_%0d got %0d want 1", i, occ_a); end
      vectors++;
      if (out_a.ctrl !== qa[0].c) begin miscompares++; $display("FAIL stream_ctrl_%0d got %0h want %0h", i, out_a.ctrl, qa[0].c); end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_a.valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain got %0b want 0", out_a.valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 96'hA;
    in_ctrl = 16'h1;
    tick();
    in_data = 96'hB;
    in_ctrl = 16'h2;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (occ_a !== 2'd2) begin miscompares++; $display("FAIL bp_occ got %0d want 2", occ_a); end
    vectors++;
    if (in_a.ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got %0b want 0", in_a.ready); end
    vectors++;
    if (out_a.data !== 96'hA) begin miscompares++; $display("FAIL bp_hold got %0h want a", out_a.data); end
    tick();
    vectors++;
    if (out_a.data !== 96'hA || occ_a !== 2'd2) begin
      miscompares++;
      $display("FAIL bp_stall got d=%0h occ=%0d want d=a occ=2", out_a.data, occ_a);
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_a.data !== 96'hB || out_a.ctrl !== 16'h2) begin
      miscompares++;
      $display("FAIL bp_second got d=%0h c=%0h want d=b c=2", out_a.data, out_a.ctrl);
    end
    vectors++;
    if (in_a.ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_back got %0b want 1", in_a.ready); end
    tick();
    vectors++;
    if (emitted_a.size() < 2 || emitted_a[emitted_a.size()-2].d !== 96'hA
        || emitted_a[emitted_a.size()-1].d !== 96'hB || occ_a !== 2'd0) begin
      miscompares++;
      $display("FAIL bp_order got occ=%0d want A then B and occ 0", occ_a);
    end
  endtask

  task automatic test_flush_full();
    bit seen;
    emitted_a.delete();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 96'h21;
    in_ctrl = 16'h11;
    tick();
    in_data = 96'h22;
    tick();
    vectors++;
    if (occ_a !== 2'd2) begin miscompares++; $display("FAIL flush_pre_occ got %0d want 2", occ_a); end
    flush = 1'b1;
    in_data = 96'hC;
    in_ctrl = 16'hC;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (out_a.valid !== 1'b0 || out_a.ctrl !== 16'h0 || occ_a !== 2'd0) begin
      miscompares++;
      $display("FAIL flush got v=%0b c=%0h occ=%0d want 0 0 0", out_a.valid, out_a.ctrl, occ_a);
    end
    out_ready = 1'b1;
    tick();
    tick();
    seen = 1'b0;
    foreach (emitted_a[i]) if (emitted_a[i].d == 96'hC) seen = 1'b1;
    vectors++;
    if (seen || out_a.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_discard got seen=%0b v=%0b want 0 0", seen, out_a.valid);
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    in_valid = 1'b0;
    in_ctrl = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (out_a.ctrl !== 16'h0) begin miscompares++; $display("FAIL bubble_%0d got %0h want 0", i, out_a.ctrl); end
    end
    in_valid = 1'b1;
    in_ctrl = 16'h0005;
    in_data = 96'h5;
    tick();
    in_valid = 1'b0;
    in_ctrl = 16'hFFFF;
    vectors++;
    if (out_a.ctrl !== 16'h0005) begin miscompares++; $display("FAIL bubble_beat got %0h want 5", out_a.ctrl); end
    tick();
    vectors++;
    if (out_a.ctrl !== 16'h0) begin miscompares++; $display("FAIL bubble_after got %0h want 0", out_a.ctrl); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 96'h31;
    in_ctrl = 16'h7;
    tick();
    in_data = 96'h32;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if (out_a.valid !== 1'b0 || out_a.ctrl !== 16'h0 || out_a.data !== 96'h0
        || occ_a !== 2'd0 || in_a.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset got v=%0b c=%0h d=%0h occ=%0d r=%0b", out_a.valid,
               out_a.ctrl, out_a.data, occ_a, in_a.ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (out_a.valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_stale_%0d got 1 want 0", i); end
    end
  endtask

  task automatic test_noskid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 96'h77;
    in_ctrl = 16'h9;
    tick();
    #1;
    vectors++;
    if (in_b.ready !== 1'b0) begin miscompares++; $display("FAIL noskid_stall got %0b want 0", in_b.ready); end
    out_ready = 1'b1;
    in_data = 96'h88;
    in_ctrl = 16'hA;
    #1;
    vectors++;
    if (in_b.ready !== 1'b1) begin miscompares++; $display("FAIL noskid_comb got %0b want 1", in_b.ready); end
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_b.data !== 96'h88 || out_b.ctrl !== 16'hA || occ_b !== 2'd1) begin
      miscompares++;
      $display("FAIL noskid_swap got d=%0h c=%0h occ=%0d want 88 a 1", out_b.data, out_b.ctrl, occ_b);
    end
    vectors++;
    if (emitted_b.size() == 0 || emitted_b[emitted_b.size()-1].d !== 96'h77) begin
      miscompares++;
      $display("FAIL noskid_emit got n=%0d want last 77", emitted_b.size());
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      rst_n     = ($urandom % 80) != 0;
      flush     = ($urandom % 25) == 0;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_data   = {$urandom, $urandom, $urandom};
      in_ctrl   = 16'($urandom);
      #1;
      vectors++;
      if (in_b.ready !== (qb.size() == 0 || out_ready)) begin
        miscompares++;
        $display("FAIL rnd_b_ready n=%0d got %0b", n, in_b.ready);
      end
      tick();
      vectors++;
      if (occ_a !== 2'(qa.size()) || out_a.valid !== (qa.size() > 0)
          || in_a.ready !== (qa.size() < 2)) begin
        miscompares++;
        $display("FAIL rnd_a_state n=%0d got occ=%0d v=%0b r=%0b want occ=%0d",
                 n, occ_a, out_a.valid, in_a.ready, qa.size());
      end
      vectors++;
      if (qa.size() > 0 ? (out_a.data !== qa[0].d || out_a.ctrl !== qa[0].c)
                        : (out_a.ctrl !== 16'h0)) begin
        miscompares++;
        $display("FAIL rnd_a_beat n=%0d got d=%0h c=%0h", n, out_a.data, out_a.ctrl);
      end
      vectors++;
      if (occ_b !== 2'(qb.size()) || out_b.valid !== (qb.size() > 0)) begin
        miscompares++;
        $display("FAIL rnd_b_state n=%0d got occ=%0d want %0d", n, occ_b, qb.size());
      end
      vectors++;
      if (qb.size() > 0 ? (out_b.data !== qb[0].d || out_b.ctrl !== qb[0].c)
                        : (out_b.ctrl !== 16'h0)) begin
        miscompares++;
        $display("FAIL rnd_b_beat n=%0d got d=%0h c=%0h", n, out_b.data, out_b.ctrl);
      end
    end
    rst_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_bubble();
    test_mid_reset();
    test_noskid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register that replaces the hand-written per-stage latch modules (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data bundle and a control bundle between stages using a valid/ready handshake, with a 2-entry skid buffer so a stage can stall without combinational ready paths.
- Synchronous flush inserts bubbles for branch mispredict and exceptions.
- Control bits are forced to zero whenever the stage holds no valid beat, so bubbles never write registers or memory.

Parameters:
- DATA_W, 96, width of the data bundle (PC, operands, immediate, register indices, packed).
- CTRL_W, 16, width of the control bundle (RegWrite, MemRead, MemWrite, Branch, ALUop, ...).
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with in_ready = !out_valid | out_ready (combinational).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard all held beats this cycle.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts this cycle (0 = stall).
- out_data  out  DATA_W  held data bundle.
- out_ctrl  out  CTRL_W  held control bundle; all-zero when out_valid = 0.
- occupancy  out  2  beats held: 0, 1 or 2.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - out_valid = 0, out_data = 0, out_ctrl = 0, occupancy = 0, skid entry cleared.
  - in_ready = 1 after reset. Input beats are ignored while rst_n is low.
- Transfers: accept when in_valid & in_ready at a clk edge; emit when out_valid & out_ready.
- States (SKID_EN = 1), encoded by occupancy:
  - EMPTY (0): in_ready = 1, out_valid = 0.
    - accept -> ONE; beat loads the main register.
  - ONE (1): in_ready = 1, out_valid = 1.
    - accept & emit -> ONE; main register gets the new beat.
    - accept & !emit -> FULL; new beat goes to the skid register.
    - emit & !accept -> EMPTY.
    - neither -> hold.
  - FULL (2): in_ready = 0, out_valid = 1.
    - emit -> ONE; skid moves to main in the same edge.
    - no emit -> hold both.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput is 1 beat/cycle with out_ready held high.
- Ordering: strictly FIFO; the skid beat never overtakes the main beat.
- in_ready is a pure register output when SKID_EN = 1. There is no combinational path from out_ready to in_ready.
- Stall: out_ready = 0 holds out_data and out_ctrl bit-stable. No stage logic may change held values.
- Flush (rst_n = 1, flush = 1):
  - Next state is EMPTY, out_valid = 0, out_ctrl = 0, occupancy = 0.
  - An input beat offered in the same cycle is discarded, even if in_ready = 1.
  - An output transfer in the same cycle still counts as completed downstream; the flush only clears what remains.
- Priority: rst_n low > flush > handshake.
- out_data is don't-care when out_valid = 0. It retains its last value, to save power; the bench must not check it.
- out_ctrl is gated to zero when out_valid = 0.
- SKID_EN = 0: occupancy is at most 1; in_ready = !out_valid | out_ready; otherwise the same rules apply.
- in_valid may drop without a transfer. in_data is sampled only on an accept.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - stage control-bundle field offsets and CTRL_W constants per stage (ID_EX_CTRL_W, EX_MEM_CTRL_W, ...);
  - the NOP/bubble control constant (all zeros).
- One natural sub-module, pipe_skid_entry: a single data+ctrl register with load/clear. It is instantiated twice: main and skid.

Test Plan:
- Reset then stream: rst_n low for 2 cycles, then 4 beats with data 0x1..0x4 and out_ready = 1 -> out_valid rises 1 cycle after the first accept; data 1,2,3,4 on consecutive cycles; occupancy stays 1.
- Backpressure fill: out_ready = 0, push beats 0xA and 0xB -> occupancy 2, in_ready = 0 on the next cycle, out_data = 0xA held. Then out_ready = 1 -> 0xA, then 0xB; in_ready returns to 1.
- Flush while FULL: occupancy 2, flush = 1 with in_valid = 1 carrying 0xC -> next cycle out_valid = 0, out_ctrl = 0, occupancy = 0; 0xC is never emitted.
- Bubble gating: in_ctrl = 0xFFFF with in_valid = 0 -> out_ctrl stays 0x0000. Then a valid beat with ctrl 0x0005 -> out_ctrl = 0x0005 for exactly one cycle.
- Mid-operation reset: occupancy 2, rst_n = 0 for 1 cycle -> all outputs at reset values and in_ready = 1; no stale beat appears afterwards.
- SKID_EN = 0: out_ready = 0 with a beat held -> in_ready = 0 in the same cycle. Toggling out_ready to 1 raises in_ready combinationally, and a new beat is accepted in the same cycle the old one leaves.
